// File: rtl/satalnk_pkg.sv
// Shared SATA link-layer definitions: primitive codes, o_prim flag positions,
// receive FSM states and the scrambler sequence helper.
package satalnk_pkg;

    localparam logic [31:0] PrimAlign = 32'hbc4a4a7b;
    localparam logic [31:0] PrimCont  = 32'h7caa9999;
    localparam logic [31:0] PrimSync  = 32'h7c95b5b5;
    localparam logic [31:0] PrimRRdy  = 32'h7c954a4a;
    localparam logic [31:0] PrimRIp   = 32'h7cb55555;
    localparam logic [31:0] PrimROk   = 32'h7cb53535;
    localparam logic [31:0] PrimRErr  = 32'h7cb55656;
    localparam logic [31:0] PrimXRdy  = 32'h7cb55757;
    localparam logic [31:0] PrimWtrm  = 32'h7cb55858;
    localparam logic [31:0] PrimHold  = 32'h7caad5d5;
    localparam logic [31:0] PrimHolda = 32'h7caa9595;
    localparam logic [31:0] PrimDmat  = 32'h7cb53636;
    localparam logic [31:0] PrimSof   = 32'h7cb53737;
    localparam logic [31:0] PrimEof   = 32'h7cb5d5d5;

    localparam int unsigned NumPrim  = 12;
    localparam int unsigned IdxSync  = 0;
    localparam int unsigned IdxRRdy  = 1;
    localparam int unsigned IdxRIp   = 2;
    localparam int unsigned IdxROk   = 3;
    localparam int unsigned IdxRErr  = 4;
    localparam int unsigned IdxXRdy  = 5;
    localparam int unsigned IdxWtrm  = 6;
    localparam int unsigned IdxHold  = 7;
    localparam int unsigned IdxHolda = 8;
    localparam int unsigned IdxDmat  = 9;
    localparam int unsigned IdxSof   = 10;
    localparam int unsigned IdxEof   = 11;

    localparam logic [15:0] ScramSeed = 16'hf0f6;

    typedef enum logic {
        StIdle,
        StFrame
    } rx_state_e;

    // Runs x^16+x^15+x^13+x^4+1 for 32 steps from a 16-bit state. Bit j of the
    // result is the j-th new bit; the top 16 bits are also the next state.
    function automatic logic [31:0] scram_word(input logic [15:0] state);
        logic [47:0] s;
        s        = '0;
        s[15:0]  = state;
        for (int j = 16; j < 48; j++) begin
            s[j] = s[j-1] ^ s[j-3] ^ s[j-12] ^ s[j-16];
        end
        return s[47:16];
    endfunction

endpackage

// File: rtl/satalnk_scrambler.sv
// 16-bit SATA scrambler LFSR producing one 32-bit keystream dword per advance;
// shared by the RX descrambler and the TX scrambler.
module satalnk_scrambler
    import satalnk_pkg::*;
#(
    parameter logic [15:0] P_SEED = ScramSeed
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_load,
    input  logic        i_ce,
    output logic [31:0] o_word
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        o_word = scram_word(lfsr_q);
        lfsr_d = lfsr_q;
        if (i_load) begin
            lfsr_d = P_SEED;
        end else if (i_ce) begin
            lfsr_d = o_word[31:16];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q <= P_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/satalnk_rxframe.sv
// SATA receive link framer: decodes primitives, frames SOF..EOF payloads,
// descrambles them and tags the CRC dword with o_last via a one-dword hold buffer.
module satalnk_rxframe
    import satalnk_pkg::*;
#(
    parameter int unsigned P_MAXLEN = 2049,
    parameter logic [15:0] P_SEED   = ScramSeed
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic               i_primitive,
    input  logic [31:0]        i_data,
    output logic               o_valid,
    output logic [31:0]        o_data,
    output logic               o_last,
    output logic [NumPrim-1:0] o_prim,
    output logic               o_prim_unk,
    output logic               o_abort,
    output logic               o_err_stray
);

    localparam int unsigned CntW = $clog2(P_MAXLEN + 1);

    rx_state_e          state_q, state_d;
    logic [31:0]        buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic               valid_q, valid_d;
    logic [31:0]        data_q, data_d;
    logic               last_q, last_d;
    logic [NumPrim-1:0] prim_q, prim_d;
    logic               unk_q, unk_d;
    logic               abort_q, abort_d;
    logic               stray_q, stray_d;

    logic               is_data;
    logic               scr_load;
    logic               scr_ce;
    logic [31:0]        scr_word;

    satalnk_scrambler #(
        .P_SEED (P_SEED)
    ) u_scrambler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (scr_load),
        .i_ce      (scr_ce),
        .o_word    (scr_word)
    );

    assign is_data = i_valid && !i_primitive;

    // CONT and ALIGN are recognised but deliberately raise no flag.
    always_comb begin
        prim_d = '0;
        unk_d  = 1'b0;
        if (i_valid && i_primitive) begin
            case (i_data)
                PrimSync:            prim_d[IdxSync]  = 1'b1;
                PrimRRdy:            prim_d[IdxRRdy]  = 1'b1;
                PrimRIp:             prim_d[IdxRIp]   = 1'b1;
                PrimROk:             prim_d[IdxROk]   = 1'b1;
                PrimRErr:            prim_d[IdxRErr]  = 1'b1;
                PrimXRdy:            prim_d[IdxXRdy]  = 1'b1;
                PrimWtrm:            prim_d[IdxWtrm]  = 1'b1;
                PrimHold:            prim_d[IdxHold]  = 1'b1;
                PrimHolda:           prim_d[IdxHolda] = 1'b1;
                PrimDmat:            prim_d[IdxDmat]  = 1'b1;
                PrimSof:             prim_d[IdxSof]   = 1'b1;
                PrimEof:             prim_d[IdxEof]   = 1'b1;
                PrimCont, PrimAlign: prim_d           = '0;
                default:             unk_d            = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        data_d     = '0;
        last_d     = 1'b0;
        abort_d    = 1'b0;
        stray_d    = 1'b0;
        scr_load   = 1'b0;
        scr_ce     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_data) begin
                    stray_d = 1'b1;
                end else if (prim_d[IdxSof]) begin
                    state_d    = StFrame;
                    buf_full_d = 1'b0;
                    cnt_d      = '0;
                    scr_load   = 1'b1;
                end
            end
            StFrame: begin
                if (is_data) begin
                    if (cnt_q == CntW'(P_MAXLEN)) begin
                        // Over-length frame: drop the held word and fall back to IDLE.
                        abort_d    = 1'b1;
                        buf_full_d = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        buf_d      = i_data ^ scr_word;
                        buf_full_d = 1'b1;
                        cnt_d      = cnt_q + CntW'(1);
                        scr_ce     = 1'b1;
                        if (buf_full_q) begin
                            valid_d = 1'b1;
                            data_d  = buf_q;
                        end
                    end
                end else if (prim_d[IdxEof]) begin
                    if (buf_full_q) begin
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        data_d  = buf_q;
                    end else begin
                        abort_d = 1'b1;
                    end
                    buf_full_d = 1'b0;
                    state_d    = StIdle;
                end else if (prim_d[IdxSof]) begin
                    abort_d    = 1'b1;
                    buf_full_d = 1'b0;
                    cnt_d      = '0;
                    scr_load   = 1'b1;
                end else if (prim_d[IdxSync] || prim_d[IdxWtrm]) begin
                    abort_d    = 1'b1;
                    buf_full_d = 1'b0;
                    state_d    = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            prim_q     <= '0;
            unk_q      <= 1'b0;
            abort_q    <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            prim_q     <= prim_d;
            unk_q      <= unk_d;
            abort_q    <= abort_d;
            stray_q    <= stray_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_last      = last_q;
    assign o_prim      = prim_q;
    assign o_prim_unk  = unk_q;
    assign o_abort     = abort_q;
    assign o_err_stray = stray_q;

endmodule
